// File: rtl/exhaustive_sweep_checker_pkg.sv
// Shared types and helpers for the exhaustive sweep checker.
//   state_e    : sweep controller states
//   to_gray    : binary-to-Gray conversion of a sweep index
//   misr_step  : one MISR update, computed on a MAX_W-bit word and masked to sig_w bits
package exhaustive_sweep_pkg;

   localparam int unsigned MAX_W = 32;

   typedef logic [MAX_W-1:0] word_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   function automatic word_t to_gray(input word_t idx);
      return idx ^ (idx >> 1);
   endfunction

   // Callers zero-extend their operands to MAX_W and truncate the result back to sig_w.
   function automatic word_t misr_step(input word_t sig, input word_t resp, input word_t poly,
                                      input int unsigned sig_w);
      word_t mask;
      word_t nxt;
      logic  msb;
      mask = (sig_w >= MAX_W) ? '1 : ((word_t'(1) << sig_w) - word_t'(1));
      msb  = sig[5'(sig_w - 1)];
      nxt  = (sig << 1) ^ (msb ? poly : '0) ^ resp;
      return nxt & mask;
   endfunction

endpackage

// File: rtl/exhaustive_sweep_checker_if.sv
// Bundle between the sweep checker and its environment.
//   master : drives start/abort/gray, the response of the block under test and exp_sig
//   slave  : the checker; drives stim, busy, done, pass and the running signature
interface exhaustive_sweep_checker_if #(
   parameter int unsigned N_IN  = 4,
   parameter int unsigned N_OUT = 2,
   parameter int unsigned SIG_W = 16
);

   logic             start;
   logic             abort;
   logic             gray;
   logic [N_OUT-1:0] resp;
   logic [SIG_W-1:0] exp_sig;
   logic [N_IN-1:0]  stim;
   logic             busy;
   logic             done;
   logic             pass;
   logic [SIG_W-1:0] signature;

   modport master (
      output start, abort, gray, resp, exp_sig,
      input  stim, busy, done, pass, signature
   );

   modport slave (
      input  start, abort, gray, resp, exp_sig,
      output stim, busy, done, pass, signature
   );

endinterface

// File: rtl/exhaustive_sweep_checker_misr_reg.sv
// Multiple-input signature register.
//   clk, rst_n : clock and asynchronous active-low reset (loads SEED)
//   clear      : synchronous reload of SEED
//   enable     : advance one MISR step absorbing resp
//   resp       : response word, zero-extended into the signature
//   sig        : current signature
//   sig_next   : value sig takes on an enabled edge (used for the end-of-sweep compare)
module misr_reg
   import exhaustive_sweep_pkg::*;
#(
   parameter int unsigned      SIG_W = 16,
   parameter int unsigned      N_OUT = 2,
   parameter logic [SIG_W-1:0] POLY  = 16'h1021,
   parameter logic [SIG_W-1:0] SEED  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [N_OUT-1:0] resp,
   output logic [SIG_W-1:0] sig,
   output logic [SIG_W-1:0] sig_next
);

   typedef logic [SIG_W-1:0] sig_t;

   sig_t sig_q;

   assign sig_next = sig_t'(misr_step(word_t'(sig_q), word_t'(resp), word_t'(POLY), SIG_W));
   assign sig      = sig_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= SEED;
      end else if (clear) begin
         sig_q <= SEED;
      end else if (enable) begin
         sig_q <= sig_next;
      end
   end

endmodule

// File: rtl/exhaustive_sweep_checker.sv
// Exhaustive truth-table sweeper with MISR response compaction.
// Walks all 2^N_IN stimulus vectors (binary or Gray order), holds each for HOLD cycles,
// folds the response sampled in each vector's last cycle into a signature and compares the
// final signature against exp_sig.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of exhaustive_sweep_checker_if (start/abort/gray/resp/exp_sig in;
//                stim/busy/done/pass/signature out, all driven from registers)
module exhaustive_sweep_checker
   import exhaustive_sweep_pkg::*;
#(
   parameter int unsigned      N_IN  = 4,
   parameter int unsigned      N_OUT = 2,
   parameter int unsigned      HOLD  = 1,
   parameter int unsigned      SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = 16'h1021,
   parameter logic [SIG_W-1:0] SEED  = '0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   exhaustive_sweep_checker_if.slave   bus
);

   localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   typedef logic [N_IN:0]   idx_t;  // one spare bit so the last-vector test cannot wrap
   typedef logic [N_IN-1:0] vec_t;
   typedef logic [HW-1:0]   hold_t;

   localparam idx_t  LAST_IDX = idx_t'((1 << N_IN) - 1);
   localparam hold_t HOLD_MAX = hold_t'(HOLD - 1);

   state_e           state_q, state_d;
   idx_t             idx_q, idx_d;
   hold_t            hold_q, hold_d;
   logic             mode_q, mode_d;
   vec_t             stim_q, stim_d;
   logic             pass_q, pass_d;
   logic             misr_clear, misr_en;
   logic [SIG_W-1:0] sig, sig_next;
   idx_t             idx_inc;
   vec_t             next_vec;

   assign idx_inc  = idx_q + idx_t'(1);
   assign next_vec = vec_t'(mode_q ? to_gray(word_t'(idx_inc)) : word_t'(idx_inc));

   misr_reg #(
      .SIG_W (SIG_W),
      .N_OUT (N_OUT),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_misr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (misr_clear),
      .enable   (misr_en),
      .resp     (bus.resp),
      .sig      (sig),
      .sig_next (sig_next)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      hold_d     = hold_q;
      mode_d     = mode_q;
      stim_d     = stim_q;
      pass_d     = pass_q;
      misr_clear = 1'b0;
      misr_en    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            // start wins over a simultaneous abort here; abort is meaningless outside RUN
            if (bus.start) begin
               state_d    = RUN;
               idx_d      = '0;
               hold_d     = '0;
               mode_d     = bus.gray;
               stim_d     = '0;  // vector 0 is all-zero in both orders
               pass_d     = 1'b0;
               misr_clear = 1'b1;
            end
         end
         RUN: begin
            // abort pre-empts a sample due on the same edge; signature keeps its partial value
            if (bus.abort) begin
               state_d = IDLE;
               idx_d   = '0;
               hold_d  = '0;
               stim_d  = '0;
               pass_d  = 1'b0;
            end else if (hold_q == HOLD_MAX) begin
               misr_en = 1'b1;
               if (idx_q < LAST_IDX) begin
                  idx_d  = idx_inc;
                  hold_d = '0;
                  stim_d = next_vec;
               end else begin
                  state_d = DONE;
                  pass_d  = (sig_next == bus.exp_sig);
               end
            end else begin
               hold_d = hold_q + hold_t'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         hold_q  <= '0;
         mode_q  <= 1'b0;
         stim_q  <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         mode_q  <= mode_d;
         stim_q  <= stim_d;
         pass_q  <= pass_d;
      end
   end

   assign bus.stim      = stim_q;
   assign bus.busy      = (state_q == RUN);
   assign bus.done      = (state_q == DONE);
   assign bus.pass      = pass_q;
   assign bus.signature = sig;

endmodule
